// File: rtl/gardner_nco.sv
// -----------------------------------------------------------------------------
// gardner_nco
//
// Timing-recovery NCO for a Gardner symbol synchroniser. A 27-bit modulo-1
// phase register eta (1.0 = 2^27) counts down by the effective step
// W = W0 + frequency_df every clock. W is clamped to [W0/2, 3*W0/2]. Each
// underflow marks an interpolation instant. The fractional interval
// mu = N/D is then derived from the pre-underflow eta (N) and the step (D).
//
// Build option:
//   GARDNER_NCO_MU_DIV_EN defined   : exact mu = floor(256*N/D). A 4-cycle
//                                     radix-4 restoring divider produces it,
//                                     so mu_valid follows strobe by 4 clk.
//   GARDNER_NCO_MU_DIV_EN undefined : mu approximates N/W0 by taking the 8
//                                     bits of N just below the W0 weight,
//                                     saturated to 255. mu_valid coincides
//                                     with strobe.
//
// Parameters:
//   W0_LOG2       nominal step W0 = 2^W0_LOG2 in units of 2^-27
//                 (legal range 8..26)
//
// Ports:
//   clk           system clock, one input sample per cycle
//   rst           asynchronous, active-high reset
//   frequency_df  signed loop-filter correction to the step (2^-27 units)
//   strobe        one-cycle pulse marking an interpolation instant
//   mu            fractional interval (value/256), held between updates
//   mu_valid      one-cycle pulse; mu is updated in the same cycle
//   w_sat         registered flag: the step was clamped in the previous cycle
// -----------------------------------------------------------------------------
module gardner_nco #(
  parameter int W0_LOG2 = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [26:0] frequency_df,
  output logic               strobe,
  output logic [7:0]         mu,
  output logic               mu_valid,
  output logic               w_sat
);

  localparam logic [27:0] W0      = 28'd1 << W0_LOG2;
  localparam logic [27:0] W_MIN   = W0 >> 1;
  localparam logic [27:0] W_MAX   = W0 + (W0 >> 1);
  localparam logic [26:0] ETA_RST = '1;

  logic [26:0]        eta_q, eta_d;
  logic               strobe_q;
  logic               w_sat_q;
  logic [7:0]         mu_q, mu_d;
  logic               mu_valid_q, mu_valid_d;

  logic signed [27:0] w_raw;
  logic signed [27:0] w_eff;
  logic signed [27:0] diff;
  logic               clamp;
  logic               underflow;

  // Step computation, clamp and phase decrement.
  // NOTE: every signal assigned in an always_comb gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_raw = $signed(W0) + $signed({frequency_df[26], frequency_df});
    w_eff = w_raw;
    clamp = 1'b0;
    if (w_raw < $signed(W_MIN)) begin
      w_eff = $signed(W_MIN);
      clamp = 1'b1;
    end else if (w_raw > $signed(W_MAX)) begin
      w_eff = $signed(W_MAX);
      clamp = 1'b1;
    end
    diff      = $signed({1'b0, eta_q}) - w_eff;
    underflow = diff[27];
    // Wrapping modulo 2^27 is just dropping the sign bit of the difference.
    eta_d     = diff[26:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eta_q      <= ETA_RST;
      strobe_q   <= 1'b0;
      w_sat_q    <= 1'b0;
      mu_q       <= 8'd0;
      mu_valid_q <= 1'b0;
    end else begin
      eta_q      <= eta_d;
      strobe_q   <= underflow;
      w_sat_q    <= clamp;
      mu_q       <= mu_d;
      mu_valid_q <= mu_valid_d;
    end
  end

`ifdef GARDNER_NCO_MU_DIV_EN

  typedef enum logic {
    S_IDLE,
    S_DIV
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [27:0] rem_q, rem_d;
  logic [27:0] den_q, den_d;
  logic [5:0]  quo_q, quo_d;

  logic [28:0] rem_x2a, rem_x2b;
  logic [27:0] rem_a, rem_b;
  logic        bit_a, bit_b;

  // Two restoring steps per clock. The remainder always stays below the
  // denominator, so the doubled value fits in one extra bit.
  always_comb begin
    rem_x2a = {rem_q, 1'b0};
    bit_a   = (rem_x2a >= {1'b0, den_q});
    rem_a   = bit_a ? 28'(rem_x2a - {1'b0, den_q}) : rem_x2a[27:0];
    rem_x2b = {rem_a, 1'b0};
    bit_b   = (rem_x2b >= {1'b0, den_q});
    rem_b   = bit_b ? 28'(rem_x2b - {1'b0, den_q}) : rem_x2b[27:0];
  end

  // Divider control. A fresh underflow always wins: it (re)loads N and D and
  // drops any division in flight, including one about to complete.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    rem_d      = rem_q;
    den_d      = den_q;
    quo_d      = quo_q;
    mu_d       = mu_q;
    mu_valid_d = 1'b0;
    if (underflow) begin
      state_d = S_DIV;
      step_d  = 2'd0;
      rem_d   = {1'b0, eta_q};
      den_d   = $unsigned(w_eff);
      quo_d   = 6'd0;
    end else begin
      case (state_q)
        S_DIV: begin
          rem_d  = rem_b;
          quo_d  = {quo_q[3:0], bit_a, bit_b};
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_d    = S_IDLE;
            mu_d       = {quo_q, bit_a, bit_b};
            mu_valid_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // NOTE: the divider datapath registers are reset along with the control so
  // the block comes out of reset in one fully defined state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      rem_q   <= 28'd0;
      den_q   <= 28'd0;
      quo_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      quo_q   <= quo_d;
    end
  end

`else

  // Approximate mu = N/W0: the 8 bits directly below the W0 weight, pinned
  // to full scale when N reaches W0 (possible when W > W0).
  always_comb begin
    mu_valid_d = underflow;
    mu_d       = mu_q;
    if (underflow) begin
      if ({1'b0, eta_q} >= W0) begin
        mu_d = 8'hFF;
      end else begin
        mu_d = eta_q[W0_LOG2-1 -: 8];
      end
    end
  end

`endif

  assign strobe   = strobe_q;
  assign mu       = mu_q;
  assign mu_valid = mu_valid_q;
  assign w_sat    = w_sat_q;

endmodule

// File: tb/tb_gardner_nco.sv
// -----------------------------------------------------------------------------
// tb_gardner_nco
//
// Scoreboard bench for gardner_nco. Two instances share clk, rst and
// frequency_df. Instance 0 uses the default W0 = 2^24. Instance 1 uses
// W0 = 2^26, where strobes can land one clock apart, so division restarts
// occur. A plain-arithmetic phase model predicts every strobe, w_sat and mu
// result when stimulus is issued. A separate monitor pops these predictions
// after each clock edge and compares them with the outputs.
// -----------------------------------------------------------------------------
module tb_gardner_nco;

  localparam int LOG2_A = 24;
  localparam int LOG2_B = 26;
  localparam longint ONE = longint'(1) << 27;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [26:0] frequency_df;
  logic [1:0]         strobe_v;
  logic [1:0]         mu_valid_v;
  logic [1:0]         w_sat_v;
  logic [1:0][7:0]    mu_v;

  gardner_nco #(.W0_LOG2(LOG2_A)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .frequency_df (frequency_df),
    .strobe       (strobe_v[0]),
    .mu           (mu_v[0]),
    .mu_valid     (mu_valid_v[0]),
    .w_sat        (w_sat_v[0])
  );

  gardner_nco #(.W0_LOG2(LOG2_B)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .frequency_df (frequency_df),
    .strobe       (strobe_v[1]),
    .mu           (mu_v[1]),
    .mu_valid     (mu_valid_v[1]),
    .w_sat        (w_sat_v[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int mu;
  } mu_exp_t;

  typedef struct {
    bit strobe;
    bit w_sat;
    bit rst;
  } cyc_exp_t;

  mu_exp_t  exp_mu_q  [2][$];
  cyc_exp_t exp_cyc_q [2][$];
  longint   eta_m     [2];
  int       st_cnt    [2];
  int       mu_hold   [2];
  int       cyc   = 0;
  int       n_vec = 0;
  int       n_bad = 0;

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] edge %0d: got %0d, expected %0d",
               name, inst, cyc, act, exp);
    end
  endtask

  function automatic longint w0_of(input int inst);
    return longint'(1) << ((inst == 0) ? LOG2_A : LOG2_B);
  endfunction

  // Predict what the instance shows after the coming clock edge.
  task automatic model_edge(input int inst, input longint df, input bit r);
    int       k;
    longint   w0, w, n;
    bit       sat, uf;
    cyc_exp_t ce;
    k = cyc + 1;
    if (r) begin
      eta_m[inst] = ONE - 1;
      exp_mu_q[inst].delete();
      ce = '{strobe: 1'b0, w_sat: 1'b0, rst: 1'b1};
    end else begin
      w0  = w0_of(inst);
      w   = w0 + df;
      sat = 1'b0;
      if (w < w0 / 2) begin
        w   = w0 / 2;
        sat = 1'b1;
      end else if (w > 3 * w0 / 2) begin
        w   = 3 * w0 / 2;
        sat = 1'b1;
      end
      n  = eta_m[inst];
      uf = (n < w);
      eta_m[inst] = uf ? n - w + ONE : n - w;
      if (uf) begin
`ifdef GARDNER_NCO_MU_DIV_EN
        // A result still pending when the next strobe rises is never reported.
        if (exp_mu_q[inst].size() > 0 &&
            exp_mu_q[inst][exp_mu_q[inst].size()-1].due >= k)
          void'(exp_mu_q[inst].pop_back());
        exp_mu_q[inst].push_back('{due: k + 4, mu: int'((256 * n) / w)});
`else
        exp_mu_q[inst].push_back('{due: k,
                                   mu: (n >= w0) ? 255 : int'(n / (w0 / 256))});
`endif
      end
      ce = '{strobe: uf, w_sat: sat, rst: 1'b0};
    end
    exp_cyc_q[inst].push_back(ce);
  endtask

  task automatic step(input longint df, input bit r);
    @(negedge clk);
    rst          = r;
    frequency_df = 27'(df);
    model_edge(0, df, r);
    model_edge(1, df, r);
  endtask

  // Hold df for n edges and count instance-0 strobes over exactly those edges.
  task automatic run(input longint df, input int n, input int exp_cnt);
    int c0, c1;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i <= n; i++) begin
      step(df, 1'b0);
      if (i == 0) c0 = st_cnt[0];
      if (i == n) c1 = st_cnt[0];
    end
    check("strobe_count", 0, c1 - c0, exp_cnt);
  endtask

  // Monitor: compare all outputs of both instances after every edge.
  initial begin : monitor
    cyc_exp_t ce;
    mu_exp_t  me;
    bit       exp_valid;
    st_cnt  = '{0, 0};
    mu_hold = '{0, 0};
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 2; i++) begin
        if (exp_cyc_q[i].size() > 0) begin
          ce        = exp_cyc_q[i].pop_front();
          exp_valid = 1'b0;
          if (ce.rst) mu_hold[i] = 0;
          if (exp_mu_q[i].size() > 0 && exp_mu_q[i][0].due == cyc) begin
            me         = exp_mu_q[i].pop_front();
            exp_valid  = 1'b1;
            mu_hold[i] = me.mu;
          end
          check("strobe",   i, strobe_v[i],   ce.strobe);
          check("w_sat",    i, w_sat_v[i],    ce.w_sat);
          check("mu_valid", i, mu_valid_v[i], exp_valid);
          check("mu",       i, mu_v[i],       mu_hold[i]);
          if (strobe_v[i]) st_cnt[i]++;
        end
      end
    end
  end

  initial begin : stimulus
    longint             df;
    logic signed [26:0] r27;
    int                 len;
    rst          = 1'b1;
    frequency_df = '0;
    eta_m        = '{ONE - 1, ONE - 1};

    // Nominal cadence, fast step, and both clamp limits.
    repeat (3) step(0, 1'b1);
    run(0, 64, 8);
    run(longint'(1) << 22, 64, 10);
    run(-(longint'(1) << 26), 64, 4);
    run((longint'(1) << 26) - 1, 64, 12);

    // Steer eta to N = 3*2^22 with D = 2^24: mu must read 192.
    repeat (2) step(0, 1'b1);
    repeat (6) step(0, 1'b0);
    step(4194303, 1'b0);
    repeat (6) step(0, 1'b0);
    check("mu_exact", 0, mu_v[0], 192);

    // Reset during the second divider cycle, then nominal cadence again.
    repeat (2) step(0, 1'b1);
    repeat (9) step(0, 1'b0);
    repeat (2) step(0, 1'b1);
    check("mu_after_rst", 0, mu_v[0], 0);
    run(0, 64, 8);

    // Random segments of held corrections, with occasional resets.
    for (int s = 0; s < 300; s++) begin
      len = $urandom_range(1, 8);
      case ($urandom_range(0, 2))
        0: df = longint'($urandom_range(0, 1 << 23)) - (longint'(1) << 22);
        1: begin
          r27 = 27'($urandom);
          df  = r27;
        end
        default: df = longint'($urandom_range(0, 1 << 24)) - (longint'(1) << 23);
      endcase
      if ($urandom_range(0, 39) == 0) repeat (2) step(0, 1'b1);
      else repeat (len) step(df, 1'b0);
    end
    repeat (8) step(0, 1'b0);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
